// File: rtl/adder_arbiter.sv
// Round-robin front end that shares one external 8-bit add/sub unit between
// NUM_REQ requesters and returns each result on a single ID-tagged response channel.
module adder_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]     req_mode,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_sum,
  output logic                   rsp_cout,
  output logic                   rsp_ovf,
  output logic [ID_W-1:0]        rsp_id,
  output logic [7:0]             add_a,
  output logic [7:0]             add_b,
  output logic                   add_mode,
  input  logic [7:0]             add_sum,
  input  logic                   add_cout,
  input  logic                   add_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic [7:0]      add_a_q, add_a_d;
  logic [7:0]      add_b_q, add_b_d;
  logic            add_mode_q, add_mode_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_sum_q, rsp_sum_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic            rsp_ovf_q, rsp_ovf_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  int              win_idx;

  // Round-robin pick: scanning from the far end down means the candidate
  // closest to rr_ptr is the last one written, so it wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; that is what keeps latches from being inferred.
    win_found = 1'b0;
    win_id    = '0;
    win_idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      win_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req_valid[win_idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(win_idx);
      end
    end
  end

  // State register: synchronous reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      add_a_q     <= 8'h00;
      add_b_q     <= 8'h00;
      add_mode_q  <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= 8'h00;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values
      // regardless of statement order.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_mode_q  <= add_mode_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_mode_d  = add_mode_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_id_d    = rsp_id_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          add_a_d    = req_a[8*int'(win_id) +: 8];
          add_b_d    = req_b[8*int'(win_id) +: 8];
          add_mode_d = req_mode[win_id];
          gnt_id_d   = win_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d   = add_sum;
        rsp_cout_d  = add_cout;
        rsp_ovf_d   = add_ovf;
        rsp_id_d    = gnt_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is offered only while idle, so the handshake and the capture share one edge.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_found) begin
      req_ready = NUM_REQ'(1) << win_id;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_mode  = add_mode_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: a behavioural add/sub unit closes the loop,
// table vectors cover arithmetic cases, short sequences cover arbitration, stalls and reset.
module tb_adder_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_mode;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [7:0]           rsp_sum;
  logic                 rsp_cout;
  logic                 rsp_ovf;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           add_a;
  logic [7:0]           add_b;
  logic                 add_mode;
  logic [7:0]           add_sum;
  logic                 add_cout;
  logic                 add_ovf;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int onehot_err = 0;

  adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_id(rsp_id),
    .add_a(add_a), .add_b(add_b), .add_mode(add_mode),
    .add_sum(add_sum), .add_cout(add_cout), .add_ovf(add_ovf)
  );

  always #5 clk = ~clk;

  // Shared adder model: add gives ovf = carry; sub gives carry = no-borrow, ovf = 0.
  logic [8:0] add_tmp;
  always_comb begin
    if (add_mode) begin
      add_tmp  = {1'b0, add_a} + {1'b0, add_b};
      add_cout = add_tmp[8];
      add_ovf  = add_tmp[8];
    end else begin
      add_tmp  = {1'b0, add_a} - {1'b0, add_b};
      add_cout = ~add_tmp[8];
      add_ovf  = 1'b0;
    end
    add_sum = add_tmp[7:0];
  end

  always @(negedge clk) begin
    if ($countones(req_ready) > 1) onehot_err++;
  end

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one cycle and land 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic mode);
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    req_mode[id]     = mode;
  endtask

  // One uncontended operation, starting and ending in IDLE, no back-pressure.
  task automatic run_op(input vec_t v, input string tag);
    set_req(v.id, v.a, v.b, v.mode);
    req_valid        = '0;
    req_valid[v.id]  = 1'b1;
    rsp_ready        = 1'b1;
    #1;
    check({tag, " req_ready"}, 32'(req_ready), 32'(1 << v.id));
    step();
    req_valid = '0;
    check({tag, " exec add_a"}, 32'(add_a), 32'(v.a));
    check({tag, " exec add_b"}, 32'(add_b), 32'(v.b));
    check({tag, " exec add_mode"}, 32'(add_mode), 32'(v.mode));
    check({tag, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " exec req_ready"}, 32'(req_ready), 32'd0);
    step();
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_sum"}, 32'(rsp_sum), 32'(v.sum));
    check({tag, " rsp_cout"}, 32'(rsp_cout), 32'(v.cout));
    check({tag, " rsp_ovf"}, 32'(rsp_ovf), 32'(v.ovf));
    check({tag, " rsp_id"}, 32'(rsp_id), 32'(v.id));
    step();
    check({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{0, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[1] = '{1, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b1, 1'b0};
    vecs[3] = '{0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b0};
    vecs[5] = '{1, 8'h40, 8'h40, 1'b1, 8'h80, 1'b0, 1'b0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_mode  = '0;
    rsp_ready = 1'b0;
    step();
    step();
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_sum", 32'(rsp_sum), 32'd0);
    check("reset rsp_cout", 32'(rsp_cout), 32'd0);
    check("reset rsp_ovf", 32'(rsp_ovf), 32'd0);
    check("reset rsp_id", 32'(rsp_id), 32'd0);
    check("reset add_a", 32'(add_a), 32'd0);
    check("reset add_b", 32'(add_b), 32'd0);
    check("reset add_mode", 32'(add_mode), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Both requesters always valid: grants alternate 0,1,0,1.
    set_req(0, 8'h10, 8'h01, 1'b1);
    set_req(1, 8'h20, 8'h02, 1'b0);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d req_ready", i), 32'(req_ready), 32'(1 << (i % 2)));
      step();
      step();
      check($sformatf("rr%0d rsp_id", i), 32'(rsp_id), 32'(i % 2));
      check($sformatf("rr%0d rsp_sum", i), 32'(rsp_sum), (i % 2 == 0) ? 32'h11 : 32'h1E);
      step();
    end

    // Back-pressure: response held for 3 cycles, no new grant until it drains.
    rsp_ready = 1'b0;
    #1;
    check("bp grant0", 32'(req_ready), 32'b01);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d rsp_sum", i), 32'(rsp_sum), 32'h11);
      check($sformatf("bp%0d rsp_id", i), 32'(rsp_id), 32'd0);
      check($sformatf("bp%0d req_ready", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp release req_ready", 32'(req_ready), 32'd0);
    step();
    check("bp regrant", 32'(req_ready), 32'b10);
    step();
    step();
    check("bp rsp_id1", 32'(rsp_id), 32'd1);
    check("bp rsp_sum1", 32'(rsp_sum), 32'h1E);
    check("bp rsp_cout1", 32'(rsp_cout), 32'd1);
    step();
    req_valid = '0;
    step();
    check("idle hold add_a", 32'(add_a), 32'h20);
    check("idle hold add_mode", 32'(add_mode), 32'd0);
    check("idle req_ready", 32'(req_ready), 32'd0);

    // Reset in EXEC: pointer returns to 0 and the discarded requester is served later.
    run_op('{0, 8'h01, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0}, "pre_rst");
    set_req(1, 8'h33, 8'h11, 1'b1);
    req_valid = 2'b10;
    #1;
    check("rst grant1", 32'(req_ready), 32'b10);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, 8'h0A, 8'h05, 1'b0);
    req_valid = 2'b11;
    #1;
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst add_mode", 32'(add_mode), 32'd1);
    check("rst add_a", 32'(add_a), 32'd0);
    check("rst rr_ptr grant0", 32'(req_ready), 32'b01);
    step();
    check("post_rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rst add_a", 32'(add_a), 32'h0A);
    check("post_rst add_mode", 32'(add_mode), 32'd0);
    step();
    check("post_rst rsp_id0", 32'(rsp_id), 32'd0);
    check("post_rst rsp_sum0", 32'(rsp_sum), 32'h05);
    check("post_rst rsp_cout0", 32'(rsp_cout), 32'd1);
    step();
    req_valid[0] = 1'b0;
    #1;
    check("post_rst regrant1", 32'(req_ready), 32'b10);
    step();
    step();
    check("post_rst rsp_id1", 32'(rsp_id), 32'd1);
    check("post_rst rsp_sum1", 32'(rsp_sum), 32'h44);
    req_valid = '0;
    step();
    check("onehot req_ready", 32'(onehot_err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
